// File: rtl/ahb_soc_top.sv
// Simulation SoC top: AHB-Lite fabric with on-chip RAM and a test-status block.
// Optional cycle-limit timeout enabled by defining CYCLE_TIMEOUT_EN.
module ahb_soc_top #(
  parameter int unsigned RAM_ADDR_WIDTH = 22,
  parameter logic [31:0] BOOT_ADDR      = 32'h80,
  parameter logic [31:0] MAX_CYCLE      = 32'd10000000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] hwdata_i,
  output logic [31:0] hrdata_o,
  output logic        hready_o,
  output logic        hresp_o,
  output logic [31:0] boot_addr_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic [31:0] cycle_cnt_o,
  output logic        timeout_o
);

  localparam int unsigned WordIdxW = RAM_ADDR_WIDTH - 2;
  localparam int unsigned RamWords = 1 << WordIdxW;

`ifdef CYCLE_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    FabReady,
    FabErr1,
    FabErr2
  } fabState_e;

  fabState_e                   state_q;
  logic                        hready_q;
  logic                        hresp_q;
  logic                        dataValid_q;
  logic                        dataWrite_q;
  logic                        dataRam_q;
  logic [RAM_ADDR_WIDTH-1:0]   dataAddr_q;
  logic [1:0]                  dataSize_q;

  logic [31:0] ramMem [RamWords];

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] exitValue_q;
  logic        exitValid_q;
  logic        passed_q;
  logic        failed_q;
  logic        timeout_q;
  logic        timeoutHit;

  logic              addrPhase;
  logic              hitRam;
  logic              hitStatus;
  logic              badSize;
  logic              misaligned;
  logic              errReq;
  logic [3:0]        byteEn;
  logic [WordIdxW-1:0] wordIdx;
  logic              ramWe;
  logic              statusWe;
  logic [31:0]       rdata;
  logic              unusedTrans;

  assign unusedTrans = htrans_i[0];

  // Address-phase decode: only NONSEQ/SEQ while the fabric is ready start a transfer.
  assign addrPhase  = hready_q && htrans_i[1];
  assign hitRam     = (haddr_i[31:RAM_ADDR_WIDTH] == '0);
  assign hitStatus  = (haddr_i[31:4] == 28'h200_0000);
  assign badSize    = (hsize_i > 3'd2);
  assign misaligned = ((hsize_i == 3'd1) && haddr_i[0]) ||
                      ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));
  assign errReq     = badSize || misaligned || !(hitRam || hitStatus);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= FabReady;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      dataValid_q <= 1'b0;
      dataWrite_q <= 1'b0;
      dataRam_q   <= 1'b0;
      dataAddr_q  <= '0;
      dataSize_q  <= '0;
    end else begin
      dataValid_q <= 1'b0;
      case (state_q)
        FabErr1: begin
          state_q  <= FabErr2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state_q  <= FabReady;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (addrPhase) begin
            if (errReq) begin
              state_q  <= FabErr1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else begin
              dataValid_q <= 1'b1;
              dataWrite_q <= hwrite_i;
              dataRam_q   <= hitRam;
              dataAddr_q  <= haddr_i[RAM_ADDR_WIDTH-1:0];
              dataSize_q  <= hsize_i[1:0];
            end
          end
        end
      endcase
    end
  end

  // Little-endian lane selection for the transfer currently in its data phase.
  always_comb begin
    byteEn = 4'b0000;
    case (dataSize_q)
      2'd0:    byteEn = 4'b0001 << dataAddr_q[1:0];
      2'd1:    byteEn = dataAddr_q[1] ? 4'b1100 : 4'b0011;
      default: byteEn = 4'b1111;
    endcase
  end

  assign wordIdx  = dataAddr_q[RAM_ADDR_WIDTH-1:2];
  assign ramWe    = dataValid_q && dataWrite_q && dataRam_q;
  assign statusWe = dataValid_q && dataWrite_q && !dataRam_q;

  always_ff @(posedge clk_i) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          ramMem[wordIdx][8*b +: 8] <= hwdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (dataValid_q && !dataWrite_q) begin
      if (dataRam_q) begin
        rdata = ramMem[wordIdx];
      end else begin
        case (dataAddr_q[3:2])
          2'd0:    rdata = exitValue_q;
          2'd1:    rdata = {30'b0, failed_q, passed_q};
          2'd2:    rdata = cnt_q;
          default: rdata = '0;
        endcase
      end
    end
  end

  assign cnt_d      = cnt_q + 32'd1;
  assign timeoutHit = TimeoutEn && (cnt_d >= MAX_CYCLE);

  // Status block: sticky flags, exit-code pulse and the free-running cycle counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      exitValue_q <= '0;
      exitValid_q <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      exitValid_q <= 1'b0;
      if (timeoutHit) begin
        timeout_q <= 1'b1;
        failed_q  <= 1'b1;
      end
      if (statusWe) begin
        case (dataAddr_q[3:2])
          2'd0: begin
            exitValue_q <= hwdata_i;
            exitValid_q <= 1'b1;
          end
          2'd1: begin
            if (hwdata_i[1]) begin
              failed_q <= 1'b1;
            end else if (hwdata_i[0]) begin
              passed_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hrdata_o       = rdata;
  assign hready_o       = hready_q;
  assign hresp_o        = hresp_q;
  assign boot_addr_o    = BOOT_ADDR;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exitValid_q;
  assign exit_value_o   = exitValue_q;
  assign cycle_cnt_o    = cnt_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_ahb_soc_top.sv
// Self-checking bench for ahb_soc_top: directed AHB transfers plus randomized RAM
// traffic checked against a byte-array reference model.
module tb_ahb_soc_top;

  localparam int unsigned RamAw    = 16;
  localparam logic [31:0] MaxCycle = 32'd2000;
  localparam logic [31:0] StatBase = 32'h2000_0000;
`ifdef CYCLE_TIMEOUT_EN
  localparam logic ToEn = 1'b1;
`else
  localparam logic ToEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;
  logic [31:0] hrdata_o;
  logic        hready_o;
  logic        hresp_o;
  logic [31:0] boot_addr_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic [31:0] cycle_cnt_o;
  logic        timeout_o;

  ahb_soc_top #(
    .RAM_ADDR_WIDTH(RamAw),
    .BOOT_ADDR(32'h80),
    .MAX_CYCLE(MaxCycle)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .haddr_i(haddr_i),
    .htrans_i(htrans_i),
    .hwrite_i(hwrite_i),
    .hsize_i(hsize_i),
    .hwdata_i(hwdata_i),
    .hrdata_o(hrdata_o),
    .hready_o(hready_o),
    .hresp_o(hresp_o),
    .boot_addr_o(boot_addr_o),
    .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o),
    .exit_value_o(exit_value_o),
    .cycle_cnt_o(cycle_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: clock edges seen since reset was last released.
  logic [31:0] tbCycles;
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tbCycles <= '0;
    else         tbCycles <= tbCycles + 32'd1;
  end

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0]  ramModel [0:255];
  logic        mPassed;
  logic        mFailed;
  logic [31:0] mExit;

  logic [31:0] rd;
  logic        fr;
  logic        rs;
  int          w;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One non-pipelined transfer; returns data/response sampled in the data phase.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic firstResp, output logic resp, output int waits);
    tick();
    haddr_i  = addr;
    htrans_i = 2'b10;
    hwrite_i = wr;
    hsize_i  = size;
    tick();
    htrans_i  = 2'b00;
    hwdata_i  = wdata;
    waits     = 0;
    firstResp = hresp_o;
    while (!hready_o && waits < 8) begin
      waits++;
      tick();
    end
    resp  = hresp_o;
    rdata = hrdata_o;
  endtask

  task automatic writeThenRead(input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic ready);
    tick();
    haddr_i  = addr;
    htrans_i = 2'b10;
    hwrite_i = 1'b1;
    hsize_i  = 3'd2;
    tick();
    hwdata_i = wdata;
    hwrite_i = 1'b0;
    tick();
    htrans_i = 2'b00;
    rdata    = hrdata_o;
    ready    = hready_o;
  endtask

  function automatic logic modelIsErr(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && addr[0]) return 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
    if (addr < (32'd1 << RamAw)) return 1'b0;
    if (addr >= StatBase && addr <= StatBase + 32'hF) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    logic [31:0] b;
    for (int i = 0; i < (1 << size); i++) begin
      b = addr + i;
      ramModel[b[7:0]] = data[8*b[1:0] +: 8];
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [31:0] addr);
    logic [7:0] a;
    a = {addr[7:2], 2'b00};
    return {ramModel[a+8'd3], ramModel[a+8'd2], ramModel[a+8'd1], ramModel[a]};
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".hready"}, 32'(hready_o), 32'd1);
    checkOutput({tag, ".hresp"}, 32'(hresp_o), 32'd0);
    checkOutput({tag, ".hrdata"}, hrdata_o, 32'd0);
    checkOutput({tag, ".flags"}, {28'b0, timeout_o, exit_valid_o, tests_failed_o, tests_passed_o}, 32'd0);
    checkOutput({tag, ".exitValue"}, exit_value_o, 32'd0);
    checkOutput({tag, ".cycleCnt"}, cycle_cnt_o, 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        wr;
    logic        isErr;
    int          sel;
    int          guard;

    rstn_i   = 1'b0;
    haddr_i  = '0;
    htrans_i = 2'b00;
    hwrite_i = 1'b0;
    hsize_i  = 3'd0;
    hwdata_i = '0;
    mPassed  = 1'b0;
    mFailed  = 1'b0;
    mExit    = '0;

    repeat (100) @(posedge clk_i);
    #1;
    checkResetState("rst.held");
    checkOutput("bootAddr", boot_addr_o, 32'h80);
    rstn_i = 1'b1;
    checkResetState("rst.released");
    tick();
    checkOutput("cnt.first", cycle_cnt_o, 32'd1);

    applyStimulus(32'h100, 1'b1, 3'd2, 32'hDEADBEEF, rd, fr, rs, w);
    checkOutput("w100.resp", 32'(rs), 32'd0);
    checkOutput("w100.waits", 32'(w), 32'd0);
    applyStimulus(32'h100, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("r100.data", rd, 32'hDEADBEEF);
    checkOutput("r100.resp", 32'(rs), 32'd0);
    checkOutput("r100.waits", 32'(w), 32'd0);
    applyStimulus(32'h101, 1'b1, 3'd0, 32'h0000_5500, rd, fr, rs, w);
    checkOutput("wb101.resp", 32'(rs), 32'd0);
    applyStimulus(32'h100, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("r100.afterByte", rd, 32'hDEAD55EF);

    applyStimulus(32'h4000_0000, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("unmapped.first", 32'(fr), 32'd1);
    checkOutput("unmapped.resp", 32'(rs), 32'd1);
    checkOutput("unmapped.waits", 32'(w), 32'd1);
    applyStimulus(32'h102, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("mis102.first", 32'(fr), 32'd1);
    checkOutput("mis102.resp", 32'(rs), 32'd1);
    checkOutput("mis102.waits", 32'(w), 32'd1);
    applyStimulus(32'h102, 1'b1, 3'd2, 32'h1234_5678, rd, fr, rs, w);
    checkOutput("mis102w.waits", 32'(w), 32'd1);
    applyStimulus(32'h100, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("r100.noSideEffect", rd, 32'hDEAD55EF);

    writeThenRead(32'h104, 32'hCAFE_F00D, rd, fr);
    checkOutput("raw104.data", rd, 32'hCAFE_F00D);
    checkOutput("raw104.ready", 32'(fr), 32'd1);

    applyStimulus(32'hFFFC, 1'b1, 3'd2, 32'hA5A5_1234, rd, fr, rs, w);
    applyStimulus(32'hFFFC, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("ramTop.data", rd, 32'hA5A5_1234);
    checkOutput("ramTop.resp", 32'(rs), 32'd0);
    applyStimulus(32'h1_0000, 1'b1, 3'd2, 32'h1, rd, fr, rs, w);
    checkOutput("ramEnd.resp", 32'(rs), 32'd1);
    checkOutput("ramEnd.waits", 32'(w), 32'd1);

    for (int a = 0; a < 256; a += 4) begin
      wdata = $urandom;
      applyStimulus(32'(a), 1'b1, 3'd2, wdata, rd, fr, rs, w);
      modelWrite(32'(a), 3'd2, wdata);
      checkOutput("init.resp", 32'(rs), 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      sel   = $urandom_range(0, 19);
      addr  = 32'($urandom_range(0, 255));
      size  = 3'($urandom_range(0, 2));
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (sel == 0) size = 3'($urandom_range(3, 7));
      if (sel == 1) addr = 32'h4000_0000 + addr;
      if (sel == 2) addr = 32'h0001_0000 + addr;
      isErr = modelIsErr(addr, size);
      applyStimulus(addr, wr, size, wdata, rd, fr, rs, w);
      checkOutput("rnd.resp", 32'(rs), 32'(isErr));
      checkOutput("rnd.waits", 32'(w), 32'(isErr));
      if (isErr) checkOutput("rnd.firstResp", 32'(fr), 32'd1);
      else if (wr) modelWrite(addr, size, wdata);
      else checkOutput("rnd.rdata", rd, modelWord(addr));
    end

    applyStimulus(StatBase, 1'b1, 3'd2, 32'd7, rd, fr, rs, w);
    checkOutput("exit.resp", 32'(rs), 32'd0);
    checkOutput("exit.preValid", 32'(exit_valid_o), 32'd0);
    mExit = 32'd7;
    tick();
    checkOutput("exit.valid", 32'(exit_valid_o), 32'd1);
    checkOutput("exit.value", exit_value_o, mExit);
    tick();
    checkOutput("exit.pulseEnd", 32'(exit_valid_o), 32'd0);
    applyStimulus(StatBase, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("exit.read", rd, mExit);

    applyStimulus(StatBase + 32'h4, 1'b1, 3'd2, 32'd1, rd, fr, rs, w);
    mPassed = 1'b1;
    tick();
    checkOutput("pass.flags", {30'b0, tests_failed_o, tests_passed_o}, {30'b0, mFailed, mPassed});
    applyStimulus(StatBase + 32'h4, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("pass.read", rd, {30'b0, mFailed, mPassed});
    applyStimulus(StatBase + 32'h8, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("cnt.read", rd, tbCycles);
    applyStimulus(StatBase + 32'h8, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, fr, rs, w);
    checkOutput("cnt.writeResp", 32'(rs), 32'd0);
    applyStimulus(StatBase + 32'hC, 1'b0, 3'd2, 32'h0, rd, fr, rs, w);
    checkOutput("reg0C.read", rd, 32'd0);
    checkOutput("cnt.live", cycle_cnt_o, tbCycles);

    // Reset asserted while an ERROR response is in flight.
    tick();
    haddr_i  = 32'h4000_0000;
    htrans_i = 2'b10;
    hwrite_i = 1'b0;
    hsize_i  = 3'd2;
    tick();
    htrans_i = 2'b00;
    checkOutput("mid.hready", 32'(hready_o), 32'd0);
    #2;
    rstn_i = 1'b0;
    #1;
    mPassed = 1'b0;
    mFailed = 1'b0;
    mExit   = '0;
    checkResetState("rst.mid");
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    guard = 0;
    while (tbCycles < MaxCycle - 32'd1 && guard < 5000) begin
      tick();
      guard++;
    end
    checkOutput("to.preCnt", cycle_cnt_o, MaxCycle - 32'd1);
    checkOutput("to.preFlag", 32'(timeout_o), 32'd0);
    checkOutput("to.preFailed", 32'(tests_failed_o), 32'd0);
    tick();
    mFailed = ToEn;
    checkOutput("to.cnt", cycle_cnt_o, MaxCycle);
    checkOutput("to.flag", 32'(timeout_o), 32'(ToEn));
    checkOutput("to.failed", 32'(tests_failed_o), 32'(mFailed));

    applyStimulus(StatBase + 32'h4, 1'b1, 3'd2, 32'd3, rd, fr, rs, w);
    mFailed = 1'b1;
    tick();
    checkOutput("both.flags", {30'b0, tests_failed_o, tests_passed_o}, {30'b0, mFailed, mPassed});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
